// File: rtl/noc_input_fifo_if.sv
// noc_input_fifo_if: flit write/pop/credit bus between a router input port FIFO and its neighbours
//   master: upstream writer + downstream reader (drives valid_in, flit_in, read_en)
//   slave : the FIFO (drives credit_out, empty, full, flit_out, flit_id, dst_addr, err)
interface noc_input_fifo_if #(parameter int DATA_WIDTH = 32);
  logic valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic read_en;
  logic credit_out;
  logic empty;
  logic full;
  logic [DATA_WIDTH-1:0] flit_out;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic err;
  modport master(output valid_in, flit_in, read_en,
                 input credit_out, empty, full, flit_out, flit_id, dst_addr, err);
  modport slave(input valid_in, flit_in, read_en,
                output credit_out, empty, full, flit_out, flit_id, dst_addr, err);
endinterface

// File: rtl/noc_input_fifo.sv
// noc_input_fifo: credit-flow-controlled show-ahead flit buffer feeding LBDR, with read-side packet framing check
//   clk, rst (async active-low); bus (slave): valid_in/flit_in write, read_en pop,
//   credit_out pulse per pop, empty/full, head flit_out/flit_id/dst_addr, sticky err
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic clk,
  input logic rst,
  noc_input_fifo_if.slave bus
);
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic [3:0] dst_hold, dst_hold_nxt;
  logic rd, wr, ovf, err_nxt;
  assign bus.empty = count == '0;
  assign bus.full = count == (PTR_W+1)'(DEPTH);
  assign rd = bus.read_en & ~bus.empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr = bus.valid_in & (~bus.full | rd);
  assign ovf = bus.valid_in & bus.full & ~rd;
  assign bus.flit_out = mem[rd_ptr];
  assign bus.flit_id = bus.flit_out[DATA_WIDTH-1 -: 3];
  // LBDR sees the live header address, else the one of the packet in flight
  assign bus.dst_addr = (bus.flit_id == HEADER && !bus.empty) ? bus.flit_out[3:0] : dst_hold;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= bus.flit_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.credit_out <= 1'b0;
      state <= IDLE;
      dst_hold <= '0;
      bus.err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr);
      rd_ptr <= rd_ptr + PTR_W'(rd);
      count <= count + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);
      bus.credit_out <= rd;
      state <= state_nxt;
      dst_hold <= dst_hold_nxt;
      bus.err <= err_nxt;
    end
  always_comb begin
    state_nxt = state;
    dst_hold_nxt = dst_hold;
    err_nxt = bus.err | ovf;
    if (rd) begin
      if (bus.flit_id == HEADER) begin
        dst_hold_nxt = bus.flit_out[3:0];
        err_nxt = err_nxt | (state == IN_PKT);
        state_nxt = IN_PKT;
      end else if (bus.flit_id == PAYLOAD) begin
        err_nxt = err_nxt | (state == IDLE);
      end else if (bus.flit_id == TAIL) begin
        err_nxt = err_nxt | (state == IDLE);
        state_nxt = IDLE;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end
endmodule

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
- Per-input-port flit buffer of the NoC router; sits directly upstream of the LBDR routing stage.
- Stores flits from the neighbouring router or NI under credit-based flow control and presents the head flit show-ahead.
- Provides the head flit's empty, flit_id and dst_addr to LBDR, and its payload to the crossbar.
- Tracks packet framing on the read side and flags protocol errors.

Parameters:
- DATA_WIDTH, 32, flit width; flit[31:29] = flit_id, flit[3:0] = destination address in HEADER flits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  router clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  upstream write strobe; flit_in is captured on the rising edge when high
- flit_in  in  DATA_WIDTH  incoming flit
- read_en  in  1  downstream (allocator/crossbar) pops the head flit this cycle
- credit_out  out  1  one-cycle pulse per flit popped; returned to upstream
- empty  out  1  FIFO holds no flits; drives LBDR empty
- full  out  1  count == DEPTH
- flit_out  out  DATA_WIDTH  head flit, combinational from memory at rd_ptr
- flit_id  out  3  flit_out[31:29]; drives LBDR flit_id
- dst_addr  out  4  flit_out[3:0] when head is HEADER, else the dst_addr latched from the last popped HEADER
- err  out  1  sticky protocol/overflow error

Behaviour:
- Reset (rst low, asynchronous, any time):
  - ptrs, count and dst_hold cleared to 0; state = IDLE.
  - Outputs: credit_out=0, err=0, empty=1, full=0.
  - Memory contents are not cleared; flit_out is don't-care while empty.
  - Reset mid-packet discards all stored flits and produces no credits.
- Storage: circular buffer; wr_ptr and rd_ptr wrap modulo DEPTH; count is PTR_W+1 bits.
- Write: valid_in & ~full, or valid_in & full & read_en & ~empty (simultaneous pop frees the slot).
  - Effect: mem[wr_ptr] <= flit_in; wr_ptr++.
  - valid_in while full without a pop: flit dropped, err set, pointers unchanged.
- Read: read_en & ~empty: rd_ptr++ and credit_out=1 on the next cycle (registered, 1-cycle latency).
  - read_en while empty is ignored: no credit, no error.
- Simultaneous valid write and pop: count unchanged.
  - On empty, write only; a read_en in the same cycle is ignored (no bypass).
- Latency: a flit written at edge N is visible on flit_out, with empty=0, after edge N.
- dst_addr:
  - Combinational flit_out[3:0] when flit_id==`HEADER and ~empty.
  - Otherwise dst_hold, which is updated with flit_out[3:0] when a HEADER is popped.
- Read-side framing FSM, advanced only on pops:
  - IDLE: pop HEADER -> IN_PKT. Pop PAYLOAD or TAIL -> err set, stay IDLE.
  - IN_PKT: pop PAYLOAD -> IN_PKT. Pop TAIL -> IDLE. Pop HEADER -> err set, stay IN_PKT, dst_hold updated.
  - Undefined flit_id values set err; the state is unchanged.
- err is cleared only by reset.
- The FIFO never reorders or modifies flits; flit_out equals flit_in bit-exact.

Test Plan:
- Reset then idle: release rst -> empty=1, full=0, credit_out=0, err=0. Assert rst low mid-packet with 3 flits stored -> empty=1 immediately, with no clock edge needed.
- Write HEADER flit 32'h2000_000A (id=`HEADER, dst 4'hA) -> next cycle empty=0, flit_id=`HEADER, dst_addr=4'hA.
  - Then write PAYLOAD and TAIL and pop all three -> three credit_out pulses, each 1 cycle after its pop.
  - dst_addr stays 4'hA through PAYLOAD and TAIL; FSM ends in IDLE; err=0.
- Fill to 4 flits -> full=1. valid_in with no pop -> flit dropped, err=1, count stays 4. Next pops return the original 4 flits in order.
- When full, assert valid_in and read_en together -> new flit accepted, full stays 1, one credit_out.
  - Repeat 8 times: pointers wrap and the output order matches the input order.
- Pop on empty -> no credit, no error. Pop a PAYLOAD while the FSM is IDLE -> err=1.
- Back-to-back packets with dst 4'h5 then 4'hF -> LBDR-facing dst_addr switches to 4'hF exactly when the second HEADER reaches the head.
